// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory responder with fixed wait-state latency
//
// Purpose: single-port word memory that accepts one load/store request at a time
// and answers it LATENCY+1 cycles later through a valid/ready response channel.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   req_valid / req_ready   request handshake (ready only while IDLE)
//   req_write               1 = store, 0 = load
//   req_addr                byte address; word index is req_addr[DEPTH_LOG2+1:2]
//   req_wdata, req_be       store data and per-byte-lane enables
//   rsp_valid / rsp_ready   response handshake
//   rsp_rdata               load data (0 for stores and errored requests)
//   rsp_err                 misaligned-access error
//   busy                    high while a transaction is in flight (WAIT or RESP)
//
// Build option: define DMEM_MISALIGN_ERR_EN to reject requests whose
// req_addr[1:0] is non-zero; otherwise those bits are ignored and rsp_err is 0.

module dmem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic                  mis_q, mis_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic [31:0]           mem [DEPTH];

   logic                  req_mis;
   logic                  enter_resp;
   logic                  mem_we;
   logic                  a_write;
   logic                  a_mis;
   logic [DEPTH_LOG2-1:0] a_idx;
   logic [31:0]           a_wdata;
   logic [3:0]            a_be;
   logic                  unused_addr_bits;

`ifdef DMEM_MISALIGN_ERR_EN
   assign req_mis = (req_addr[1:0] != 2'b00);
`else
   assign req_mis = 1'b0;
`endif

   assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

   // With LATENCY=0 the access happens on the accept edge itself, before the
   // request has been captured, so the access fields come straight from the inputs.
   always_comb begin
      if (state_q == IDLE) begin
         a_write = req_write;
         a_mis   = req_mis;
         a_idx   = req_addr[DEPTH_LOG2+1:2];
         a_wdata = req_wdata;
         a_be    = req_be;
      end else begin
         a_write = write_q;
         a_mis   = mis_q;
         a_idx   = idx_q;
         a_wdata = wdata_q;
         a_be    = be_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      mis_d      = mis_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               idx_d   = req_addr[DEPTH_LOG2+1:2];
               wdata_d = req_wdata;
               be_d    = req_be;
               mis_d   = req_mis;
               if (LATENCY == 0) begin
                  state_d    = RESP;
                  cnt_d      = 4'd0;
                  enter_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(LATENCY);
               end
            end
         end
         WAIT: begin
            // <=1 rather than ==1 so a corrupted zero count cannot wrap to 15
            if (cnt_q <= 4'd1) begin
               state_d    = RESP;
               cnt_d      = 4'd0;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      // The response is latched once on RESP entry and held until the handshake.
      if (enter_resp) begin
         rdata_d = (a_write || a_mis) ? 32'd0 : mem[a_idx];
         err_d   = a_mis;
      end
   end

   assign mem_we = enter_resp && a_write && !a_mis;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         mis_q   <= 1'b0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         mis_q   <= mis_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (a_be[b]) begin
               mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
            end
         end
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed bench for dmem_responder (defaults DEPTH_LOG2=8, LATENCY=2)

module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_be = 4'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int tests = 0;
   int fails = 0;

   dmem_responder dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at a negedge after the response handshake.
   // lat counts cycles from the accept cycle (0) to the first rsp_valid cycle.
   task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd,
                         output logic er, output int lat);
      int n;
      req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      if (!req_ready) begin
         tests++; fails++;
         $display("FAIL accept_timeout addr=%h got req_ready=0 want 1", a);
      end
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      rd = rsp_rdata; er = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
      tests++; if (rsp_rdata !== 32'd0) begin fails++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
      tests++; if (rsp_err !== 1'b0) begin fails++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL store_latency got %0d want 3", lat); end
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL store_rdata got %h want 0", rd); end
      do_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL load_latency got %0d want 3", lat); end
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h want deadbeef", rd); end
      tests++; if (er !== 1'b0) begin fails++; $display("FAIL load_err got %b want 0", er); end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b1, 32'h10, 32'h00000055, 4'b0001, rd, er, lat);
      do_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hDEADBE55) begin fails++; $display("FAIL partial_rdata got %h want deadbe55", rd); end
      do_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL be0_latency got %0d want 3", lat); end
      do_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hDEADBE55) begin fails++; $display("FAIL be0_rdata got %h want deadbe55", rd); end
      do_txn(1'b1, 32'h14, 32'hAABBCCDD, 4'b1010, rd, er, lat);
      do_txn(1'b1, 32'h14, 32'h11223344, 4'b0101, rd, er, lat);
      do_txn(1'b0, 32'h14, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hAA22CC44) begin fails++; $display("FAIL lanes_rdata got %h want aa22cc44", rd); end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd; logic er; int lat; int n;
      req_write = 1'b0; req_addr = 32'h10; req_be = 4'b0000; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      // Queue a store that must wait until the stalled load completes.
      req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hA5A5A5A5; req_be = 4'b1111;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_timeout got rsp_valid=%b want 1", rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBE55 || req_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold cycle %0d got v=%b d=%h rr=%b busy=%b want v=1 d=deadbe55 rr=0 busy=1",
                     i, rsp_valid, rsp_rdata, req_ready, busy);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got rr=%b v=%b want rr=1 v=0", req_ready, rsp_valid); end
      // Pending store is accepted on the next edge.
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL pending_accept got busy=%b want 1", busy); end
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      do_txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL pending_store_rdata got %h want a5a5a5a5", rd); end
   endtask

   task automatic test_wrap();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b1, 32'h400, 32'h12345678, 4'b1111, rd, er, lat);
      do_txn(1'b0, 32'h000, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL wrap_rdata got %h want 12345678", rd); end
      do_txn(1'b0, 32'hFFFF_F010, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hDEADBE55) begin fails++; $display("FAIL wrap_high_rdata got %h want deadbe55", rd); end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b1, 32'h20, 32'h11223344, 4'b1111, rd, er, lat);
      req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'b1111; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      tests++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL wait_state got busy=%b v=%b want busy=1 v=0", busy, rsp_valid); end
      reset = 1'b1;
      #1;
      tests++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
         fails++;
         $display("FAIL rst_wait_outputs got rr=%b busy=%b v=%b d=%h e=%b want rr=1 busy=0 v=0 d=0 e=0",
                  req_ready, busy, rsp_valid, rsp_rdata, rsp_err);
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_txn(1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'h11223344) begin fails++; $display("FAIL rst_wait_nowrite got %h want 11223344", rd); end
   endtask

   task automatic test_reset_in_resp();
      logic [31:0] rd; logic er; int lat; int n;
      req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_be = 4'b1111; req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      reset = 1'b1;
      #1;
      tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rst_resp_drop got v=%b rr=%b want v=0 rr=1", rsp_valid, req_ready); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_txn(1'b0, 32'h24, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL rst_resp_committed got %h want cafef00d", rd); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic er; int lat;
      do_txn(1'b0, 32'h13, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (lat != 3) begin fails++; $display("FAIL mis_latency got %0d want 3", lat); end
`ifdef DMEM_MISALIGN_ERR_EN
      tests++; if (er !== 1'b1) begin fails++; $display("FAIL mis_err got %b want 1", er); end
      tests++; if (rd !== 32'd0) begin fails++; $display("FAIL mis_rdata got %h want 0", rd); end
      do_txn(1'b1, 32'h11, 32'h00000000, 4'b1111, rd, er, lat);
      tests++; if (er !== 1'b1) begin fails++; $display("FAIL mis_store_err got %b want 1", er); end
      do_txn(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
      tests++; if (rd !== 32'hDEADBE55 || er !== 1'b0) begin fails++; $display("FAIL mis_store_nowrite got %h/%b want deadbe55/0", rd, er); end
`else
      tests++; if (er !== 1'b0) begin fails++; $display("FAIL mis_err got %b want 0", er); end
      tests++; if (rd !== 32'hDEADBE55) begin fails++; $display("FAIL mis_rdata got %h want deadbe55", rd); end
`endif
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_partial_store();
      test_backpressure();
      test_wrap();
      test_reset_in_wait();
      test_reset_in_resp();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DEPTH_LOG2, default 8, SHALL set the number of words to 2^DEPTH_LOG2.
REQ-003 Parameter LATENCY, default 2, SHALL set the wait-state cycles between request acceptance and response (legal range 0..15).
REQ-004 The module SHALL have the following ports:
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i enables byte lane i
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  32  load data; 0 for stores
- rsp_err  out  1  misaligned-access error
- busy  out  1  FSM not in IDLE

Function
REQ-005 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in WAIT and RESP.
REQ-007 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; req_write, req_addr, req_wdata and req_be SHALL be captured at that edge.
REQ-008 On accept, the FSM SHALL go IDLE->WAIT and load the wait counter with LATENCY; if LATENCY=0 it SHALL go IDLE->RESP.
REQ-009 In WAIT the counter SHALL decrement each cycle; the FSM SHALL move WAIT->RESP on the edge where the counter equals 1.
REQ-010 The memory access (store commit or load read) SHALL occur on the edge that enters RESP; rsp_valid SHALL rise LATENCY+1 cycles after the accept edge.
REQ-011 A store SHALL write only the byte lanes whose req_be bit is 1.
REQ-012 A store with req_be=0000 SHALL leave memory unchanged and SHALL still respond.
REQ-013 The word index SHALL be req_addr[DEPTH_LOG2+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
REQ-014 rsp_rdata and rsp_err SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-015 On the edge where rsp_valid=1 and rsp_ready=1, the FSM SHALL go RESP->IDLE; req_ready SHALL be 1 in the following cycle.
REQ-016 Accept and response SHALL never occur in the same cycle; throughput SHALL be at most one transaction per LATENCY+2 cycles.
REQ-017 req_valid asserted in WAIT or RESP SHALL be ignored; the request SHALL remain pending and SHALL be accepted after the return to IDLE.
REQ-018 A load from a just-written word SHALL return the stored data; read-after-write across transactions SHALL be coherent.

Reset
REQ-019 While reset=1, the FSM SHALL be in IDLE and the wait counter SHALL be 0.
REQ-020 While reset=1, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-021 Reset asserted in WAIT SHALL abort the transaction with no memory write.
REQ-022 Reset asserted in RESP SHALL drop the response; a store already committed on RESP entry SHALL remain committed.
REQ-023 Memory array contents SHALL not be cleared by reset.

Configuration
REQ-024 Macro DMEM_MISALIGN_ERR_EN SHALL compile the misalignment check in or out.
REQ-025 With DMEM_MISALIGN_ERR_EN defined, a request with req_addr[1:0]!=00 SHALL perform no memory access and SHALL respond with rsp_err=1 and rsp_rdata=0, with the same timing as an aligned request.
REQ-026 Without DMEM_MISALIGN_ERR_EN, req_addr[1:0] SHALL be ignored and rsp_err SHALL be tied to 0.

Verification
REQ-027 Directed scenario, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be=1111; then load 0x10 -> rsp_rdata=0xDEADBEEF, with rsp_valid 3 cycles after each accept.
REQ-028 Directed scenario, partial store: store 0x10, wdata 0x00000055, be=0001 over 0xDEADBEEF; then load 0x10 -> 0xDEADBE55.
REQ-029 Directed scenario, backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and req_ready=0 stay stable; release -> IDLE next cycle.
REQ-030 Directed scenario, DEPTH_LOG2=8: store 0x400 with 0x12345678; then load 0x000 -> 0x12345678 (wrap).
REQ-031 Directed scenario, reset in WAIT during store 0x20 of 0xFFFFFFFF; then load 0x20 -> prior value; all outputs at reset values during reset.
REQ-032 Directed scenario, misaligned load 0x13: with DMEM_MISALIGN_ERR_EN -> rsp_err=1, rsp_rdata=0; without it -> rsp_err=0 and data of word 0x10.
